// File: rtl/cve2_ex_result_sequencer.sv
// In-order issue/writeback sequencer for the EX stage: dispatches ops to multi-cycle units,
// buffers each unit's result in a one-entry holding register and retires results in issue order.
module cve2_ex_result_sequencer #(
   parameter int unsigned NUM_UNITS = 3,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned DATA_W    = 32,
   localparam int unsigned UID_W    = $clog2(NUM_UNITS),
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        issue_valid_i,
   input  logic [UID_W-1:0]            issue_unit_i,
   output logic                        issue_ready_o,
   output logic                        issue_err_o,
   output logic [NUM_UNITS-1:0]        unit_valid_o,
   input  logic [NUM_UNITS-1:0]        unit_ready_i,
   input  logic [NUM_UNITS-1:0]        unit_rvalid_i,
   input  logic [NUM_UNITS*DATA_W-1:0] unit_rdata_i,
   output logic [NUM_UNITS-1:0]        unit_rready_o,
   output logic                        result_valid_o,
   output logic [DATA_W-1:0]           result_o,
   output logic [UID_W-1:0]            result_unit_o,
   input  logic                        result_ready_i,
   input  logic                        flush_i,
   output logic [NUM_UNITS-1:0]        unit_flush_o,
   output logic                        busy_o,
   output logic [CNT_W-1:0]            outstanding_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [UID_W-1:0]      fifo_q [DEPTH];
   logic [NUM_UNITS-1:0]  hold_valid_q, hold_valid_d;
   logic [DATA_W-1:0]     hold_data_q [NUM_UNITS];
   logic [CNT_W-1:0]      pend_q [NUM_UNITS];
   logic [CNT_W-1:0]      pend_d [NUM_UNITS];
   logic                  issue_err_q, issue_err_d;

   logic                  empty, full, legal, sel_ready, fire, push, deq;
   logic [UID_W-1:0]      head;
   logic                  head_hv;
   logic [DATA_W-1:0]     head_data;
   logic [NUM_UNITS-1:0]  cap;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = fifo_q[rd_ptr_q[AW-1:0]];
   assign legal = (32'(issue_unit_i) < NUM_UNITS);

   // Issue side; an illegal unit ID is accepted so it can be reported rather than stall ID.
   always_comb begin
      sel_ready    = 1'b1;
      unit_valid_o = '0;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
         if (issue_unit_i == UID_W'(k)) begin
            sel_ready       = unit_ready_i[k];
            unit_valid_o[k] = issue_valid_i & ~flush_i & ~full;
         end
      end
   end

   assign issue_ready_o = ~flush_i & ~full & sel_ready;
   assign fire          = issue_valid_i & issue_ready_o;
   assign push          = fire & legal;

   always_comb begin
      head_hv   = 1'b0;
      head_data = '0;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
         if (head == UID_W'(k)) begin
            head_hv   = hold_valid_q[k];
            head_data = hold_data_q[k];
         end
      end
   end

   assign result_valid_o = ~empty & head_hv;
   assign result_o       = head_data;
   assign result_unit_o  = head;
   assign deq            = result_valid_o & result_ready_i;

   // A full holding register may still accept when its content retires this same cycle.
   always_comb begin
      unit_rready_o = '0;
      cap           = '0;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
         unit_rready_o[k] = ~flush_i & (pend_q[k] != '0) &
                            (~hold_valid_q[k] | (deq & (head == UID_W'(k))));
         cap[k]           = unit_rvalid_i[k] & unit_rready_o[k];
      end
   end

   always_comb begin
      hold_valid_d = hold_valid_q;
      wr_ptr_d     = wr_ptr_q + (AW+1)'(push);
      rd_ptr_d     = rd_ptr_q + (AW+1)'(deq);
      issue_err_d  = fire & ~legal;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
         pend_d[k] = pend_q[k] + CNT_W'(push & (issue_unit_i == UID_W'(k))) - CNT_W'(cap[k]);
         if (cap[k]) begin
            hold_valid_d[k] = 1'b1;
         end else if (deq && (head == UID_W'(k))) begin
            hold_valid_d[k] = 1'b0;
         end
         if (flush_i) begin
            pend_d[k] = '0;
         end
      end
      if (flush_i) begin
         hold_valid_d = '0;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         hold_valid_q <= '0;
         issue_err_q  <= 1'b0;
         for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            pend_q[k] <= '0;
         end
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         hold_valid_q <= hold_valid_d;
         issue_err_q  <= issue_err_d;
         for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            pend_q[k] <= pend_d[k];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_q[wr_ptr_q[AW-1:0]] <= issue_unit_i;
      end
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
         if (cap[k]) begin
            hold_data_q[k] <= unit_rdata_i[k*DATA_W +: DATA_W];
         end
      end
   end

   assign issue_err_o   = issue_err_q;
   assign unit_flush_o  = {NUM_UNITS{flush_i}};
   assign busy_o        = ~empty | (|hold_valid_q);
   assign outstanding_o = CNT_W'(wr_ptr_q - rd_ptr_q);

endmodule

// File: tb/tb_cve2_ex_result_sequencer.sv
// Bench for cve2_ex_result_sequencer: issue-port vector table, per-unit result models and an
// in-order scoreboard, plus directed sequences for full, stall, flush, streaming and reset.
`timescale 1ns/1ps
module tb_cve2_ex_result_sequencer;
   localparam int unsigned NU = 3;
   localparam int unsigned DP = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned UW = 2;
   localparam int unsigned CW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              issue_valid = 1'b0;
   logic [UW-1:0]     issue_unit = '0;
   logic [DW-1:0]     issue_data = '0;
   logic              issue_ready, issue_err;
   logic [NU-1:0]     unit_valid, unit_rready, unit_flush;
   logic [NU-1:0]     unit_ready = '1;
   logic [NU-1:0]     unit_rvalid = '0;
   logic [NU*DW-1:0]  unit_rdata = '0;
   logic              result_valid;
   logic [DW-1:0]     result;
   logic [UW-1:0]     result_unit;
   logic              result_ready = 1'b1;
   logic              flush = 1'b0;
   logic              busy;
   logic [CW-1:0]     outstanding;
   logic [NU-1:0]     unit_en = '1;
   logic [NU-1:0]     force_rvalid = '0;

   cve2_ex_result_sequencer #(.NUM_UNITS(NU), .DEPTH(DP), .DATA_W(DW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(issue_valid), .issue_unit_i(issue_unit),
      .issue_ready_o(issue_ready), .issue_err_o(issue_err),
      .unit_valid_o(unit_valid), .unit_ready_i(unit_ready),
      .unit_rvalid_i(unit_rvalid), .unit_rdata_i(unit_rdata), .unit_rready_o(unit_rready),
      .result_valid_o(result_valid), .result_o(result), .result_unit_o(result_unit),
      .result_ready_i(result_ready), .flush_i(flush), .unit_flush_o(unit_flush),
      .busy_o(busy), .outstanding_o(outstanding)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [UW-1:0] unit;
      logic [DW-1:0] data;
   } sb_t;

   sb_t         sb [$];
   logic [DW-1:0] uq [NU][$];
   logic        err_exp = 1'b0;
   int          cyc = 0;
   int          deq_cnt = 0;
   int          deq_at [1024];

   // Monitor: sample every handshake mid-cycle, update scoreboard and unit models.
   always begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         sb.delete();
         for (int k = 0; k < NU; k++) uq[k].delete();
         err_exp = 1'b0;
      end else begin
         chk("issue_err", issue_err, err_exp);
         chk("outstanding", outstanding, sb.size());
         chk("unit_flush", unit_flush, {NU{flush}});
         if (result_valid && result_ready) begin
            if (sb.size() == 0) begin
               chk("deq_unexpected", result_valid, 0);
            end else begin
               sb_t e;
               e = sb.pop_front();
               chk("result_unit", result_unit, e.unit);
               chk("result_data", result, e.data);
            end
            deq_at[deq_cnt % 1024] = cyc;
            deq_cnt++;
         end
         err_exp = 1'b0;
         if (issue_valid && issue_ready) begin
            if (issue_unit < NU) sb.push_back('{issue_unit, issue_data});
            else err_exp = 1'b1;
         end
         for (int k = 0; k < NU; k++) begin
            if (unit_valid[k] && unit_ready[k]) uq[k].push_back(issue_data);
         end
         for (int k = 0; k < NU; k++) begin
            if (unit_rvalid[k] && unit_rready[k]) begin
               if (uq[k].size() == 0) chk("spurious_capture", unit_rready[k], 0);
               else void'(uq[k].pop_front());
            end
         end
         for (int k = 0; k < NU; k++) begin
            if (unit_flush[k]) uq[k].delete();
         end
         if (flush) sb.delete();
      end
   end

   // Unit result drivers: present the oldest accepted op's result when enabled.
   always begin
      @(posedge clk);
      #2;
      for (int k = 0; k < NU; k++) begin
         unit_rvalid[k] = (unit_en[k] && uq[k].size() != 0) || force_rvalid[k];
         unit_rdata[k*DW +: DW] = (uq[k].size() != 0) ? uq[k][0] : (32'hBAD0_0000 | k);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_op(input logic [UW-1:0] u, input logic [DW-1:0] d);
      bit ok = 1'b0;
      issue_valid = 1'b1;
      issue_unit  = u;
      issue_data  = d;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = issue_ready;
         if (!ok) tick();
      end
      chk("issue_accept", ok, 1);
      tick();
      issue_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      bit done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         done = (sb.size() == 0) && !busy;
      end
      chk({name, "_drain"}, done, 1);
      tick();
   endtask

   typedef struct {
      logic          v;
      logic [UW-1:0] u;
      logic [NU-1:0] ur;
      logic          f;
      logic [DW-1:0] d;
      logic          exp_ready;
      logic [NU-1:0] exp_uv;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int n0;
      bit seen;
      tbl[0] = '{1'b1, 2'd0, 3'b111, 1'b0, 32'hA000_0001, 1'b1, 3'b001};
      tbl[1] = '{1'b1, 2'd1, 3'b101, 1'b0, 32'hA000_0002, 1'b0, 3'b010};
      tbl[2] = '{1'b1, 2'd2, 3'b111, 1'b1, 32'hA000_0003, 1'b0, 3'b000};
      tbl[3] = '{1'b0, 2'd2, 3'b111, 1'b0, 32'hA000_0004, 1'b1, 3'b000};
      tbl[4] = '{1'b1, 2'd3, 3'b000, 1'b0, 32'hA000_0005, 1'b1, 3'b000};
      tbl[5] = '{1'b1, 2'd2, 3'b100, 1'b0, 32'hA000_0006, 1'b1, 3'b100};
      tbl[6] = '{1'b1, 2'd1, 3'b010, 1'b0, 32'hA000_0007, 1'b1, 3'b010};

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_issue_err", issue_err, 0);
      chk("rst_rready", unit_rready, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Issue-port vector table, applied from an idle sequencer
      for (int i = 0; i < 7; i++) begin
         issue_valid = tbl[i].v;
         issue_unit  = tbl[i].u;
         unit_ready  = tbl[i].ur;
         flush       = tbl[i].f;
         issue_data  = tbl[i].d;
         @(negedge clk);
         chk($sformatf("vec%0d_issue_ready", i), issue_ready, tbl[i].exp_ready);
         chk($sformatf("vec%0d_unit_valid", i), unit_valid, tbl[i].exp_uv);
         tick();
         issue_valid = 1'b0;
         flush       = 1'b0;
         unit_ready  = '1;
         wait_drain($sformatf("vec%0d", i));
      end

      // Out-of-order completion returned in issue order 0,1,0
      unit_en = 3'b101;
      n0 = deq_cnt;
      issue_op(2'd0, 32'h1111_0001);
      issue_op(2'd1, 32'h2222_0002);
      issue_op(2'd0, 32'h1111_0003);
      tick();
      tick();
      @(negedge clk);
      chk("t1_blocked_deqs", deq_cnt - n0, 1);
      chk("t1_blocked_valid", result_valid, 0);
      chk("t1_blocked_busy", busy, 1);
      tick();
      unit_en = '1;
      wait_drain("t1");
      chk("t1_total_deqs", deq_cnt - n0, 3);

      // Full FIFO blocks issue, including on the cycle of a dequeue
      unit_en = '0;
      for (int i = 0; i < 4; i++) issue_op(2'd0, 32'h3000_0000 + i);
      issue_valid = 1'b1;
      issue_unit  = 2'd1;
      issue_data  = 32'h3100_0000;
      @(negedge clk);
      chk("t2_outstanding_full", outstanding, 4);
      chk("t2_full_ready", issue_ready, 0);
      tick();
      unit_en = 3'b001;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = result_valid && result_ready;
         if (!seen) tick();
      end
      chk("t2_deq_seen", seen, 1);
      chk("t2_full_on_deq", issue_ready, 0);
      tick();
      @(negedge clk);
      chk("t2_ready_after_pop", issue_ready, 1);
      tick();
      issue_valid = 1'b0;
      unit_en = '1;
      wait_drain("t2");

      // Stalled writeback holds head data and back-pressures the unit
      unit_en = '0;
      result_ready = 1'b0;
      issue_op(2'd0, 32'hDEAD_BEEF);
      issue_op(2'd0, 32'h1234_5678);
      unit_en = 3'b001;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = result_valid;
         if (!seen) tick();
      end
      chk("t4_valid_seen", seen, 1);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", result_valid, 1);
         chk("t4_hold_data", result, 32'hDEAD_BEEF);
         chk("t4_hold_unit", result_unit, 0);
         chk("t4_rready_blocked", unit_rready[0], 0);
         tick();
      end
      result_ready = 1'b1;
      unit_en = '1;
      wait_drain("t4");

      // Flush with three ops in flight and one younger result held
      unit_en = '0;
      issue_op(2'd0, 32'h5000_0000);
      issue_op(2'd1, 32'h5000_0001);
      issue_op(2'd2, 32'h5000_0002);
      unit_en = 3'b100;
      repeat (3) tick();
      @(negedge clk);
      chk("t5_pre_busy", busy, 1);
      chk("t5_pre_valid", result_valid, 0);
      chk("t5_pre_outstanding", outstanding, 3);
      tick();
      flush = 1'b1;
      @(negedge clk);
      chk("t5_flush_rready", unit_rready, 0);
      chk("t5_flush_issue_ready", issue_ready, 0);
      tick();
      flush = 1'b0;
      unit_en = '0;
      force_rvalid = 3'b011;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_post_busy", busy, 0);
         chk("t5_post_rready", unit_rready, 0);
         chk("t5_post_valid", result_valid, 0);
         tick();
      end
      force_rvalid = '0;
      unit_en = '1;
      tick();

      // Streaming through one unit at one result per cycle
      n0 = deq_cnt;
      for (int i = 0; i < 16; i++) issue_op(2'd0, 32'h6000_0000 + i);
      wait_drain("t6");
      chk("t6_count", deq_cnt - n0, 16);
      chk("t6_no_bubbles", deq_at[(n0 + 15) % 1024] - deq_at[n0 % 1024], 15);

      // Asynchronous reset in the middle of activity
      unit_en = '0;
      issue_op(2'd0, 32'h7000_0000);
      issue_op(2'd1, 32'h7000_0001);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_async_busy", busy, 0);
      chk("t7_async_outstanding", outstanding, 0);
      chk("t7_async_valid", result_valid, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      unit_en = '1;
      tick();
      issue_op(2'd1, 32'h7777_0000);
      wait_drain("t7");

      chk("final_sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
